// File: rtl/ram_pkg.sv
// Shared constants and helpers for the parametrised single-port RAM.
// Read and write mode encodings plus depth derivation from the address width.
package ram_pkg;

   localparam int unsigned RD_BYPASS  = 0;
   localparam int unsigned RD_PIPE    = 1;

   localparam int unsigned WR_NORMAL  = 0;
   localparam int unsigned WR_THROUGH = 1;
   localparam int unsigned WR_RBW     = 2;

   function automatic int unsigned ram_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Power-on clear sequencer: walks every address once after reset, holding busy high.
// done_o pulses for one cycle on the cycle busy first reads low after a full sweep.
module ram_clear_seq #(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic              busy_o,
   output logic [ADDR_W-1:0] clr_addr_o,
   output logic              done_o
);

   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q <= (CLEAR_ON_RESET != 0);
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
         // Last address written on this edge; busy falls together with it.
         if (cnt_q == {ADDR_W{1'b1}}) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   assign busy_o     = busy_q;
   assign clr_addr_o = cnt_q;
   assign done_o     = done_q;

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with optional post-reset clear sweep.
// Array has no reset so synthesis maps it onto block RAM.
module ram_sp_param #(
   parameter int unsigned        DATA_W         = 8,
   parameter int unsigned        ADDR_W         = 8,
   parameter int unsigned        READ_MODE      = 0,
   parameter int unsigned        WRITE_MODE     = 0,
   parameter int unsigned        CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              oce,
   input  logic              wre,
   input  logic [ADDR_W-1:0] ad,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              busy
);
   import ram_pkg::*;

   localparam int unsigned DEPTH = ram_depth(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_done;
   logic [ADDR_W-1:0] clr_addr;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] rd_q, rd_d;

   ram_clear_seq #(
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk_i      (clk),
      .rst_ni     (reset),
      .busy_o     (busy),
      .clr_addr_o (clr_addr),
      .done_o     (clr_done)
   );

   always_comb begin
      if (clr_done) begin
         assert (!busy);
      end
   end

   // Clear sweep owns the write port while busy; user writes only afterwards.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = ad;
      mem_wdata = din;
      if (reset) begin
         if (busy) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = CLEAR_VALUE;
         end else begin
            mem_we    = ce & wre;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign mem_rdata = mem[ad];

   always_comb begin
      rd_d = rd_q;
      if (!busy && ce) begin
         if (!wre) begin
            rd_d = mem_rdata;
         end else if (WRITE_MODE == WR_THROUGH) begin
            rd_d = din;
         end else if (WRITE_MODE == WR_RBW) begin
            rd_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   if (READ_MODE == RD_PIPE) begin : g_pipe
      logic [DATA_W-1:0] dout_q;

      always_ff @(posedge clk) begin
         if (!reset) begin
            dout_q <= '0;
         end else if (oce && !busy) begin
            dout_q <= rd_q;
         end
      end

      assign dout = dout_q;
   end else begin : g_bypass
      logic unused_oce;
      assign unused_oce = oce;
      assign dout       = rd_q;
   end

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: three bypass instances (one per write mode) and a
// pipelined instance share stimulus; an array model is compared every cycle.
module tb_ram_sp_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce, oce, wre;
   logic [3:0] ad;
   logic [7:0] din;

   logic [7:0] dout_w0, dout_w1, dout_w2, dout_p;
   logic       busy_w0, busy_w1, busy_w2, busy_p;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_wm0 (
      .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
      .dout(dout_w0), .busy(busy_w0));

   ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(1),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_wm1 (
      .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
      .dout(dout_w1), .busy(busy_w1));

   ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(2),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_wm2 (
      .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
      .dout(dout_w2), .busy(busy_w2));

   ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1), .WRITE_MODE(0),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_pipe (
      .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
      .dout(dout_p), .busy(busy_p));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain array plus one read register per write mode.
   logic [7:0] mem_m [16];
   logic [7:0] rd_m  [3];
   logic [7:0] pout_m;
   logic       busy_m;
   int         clr_left;
   bit         model_ok = 1'b0;

   always @(posedge clk) begin
      logic [7:0] old;
      if (!reset) begin
         busy_m   = 1'b1;
         clr_left = 16;
         for (int k = 0; k < 3; k++) rd_m[k] = 8'h00;
         pout_m   = 8'h00;
         model_ok = 1'b1;
      end else if (busy_m) begin
         mem_m[16 - clr_left] = 8'hA5;
         clr_left--;
         if (clr_left == 0) busy_m = 1'b0;
      end else begin
         if (oce) pout_m = rd_m[0];
         if (ce) begin
            old = mem_m[ad];
            if (!wre) begin
               for (int k = 0; k < 3; k++) rd_m[k] = old;
            end else begin
               mem_m[ad] = din;
               rd_m[1]   = din;
               rd_m[2]   = old;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("busy_all", {busy_w0, busy_w1, busy_w2, busy_p}, {4{busy_m}});
         check("dout_wm0", dout_w0, rd_m[0]);
         check("dout_wm1", dout_w1, rd_m[1]);
         check("dout_wm2", dout_w2, rd_m[2]);
         check("dout_pipe", dout_p, pout_m);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic c, input logic w, input logic [3:0] a, input logic [7:0] d,
                     input logic o);
      ce = c; wre = w; ad = a; din = d; oce = o;
      tick();
   endtask

   task automatic count_clear(input string name);
      int edges = 0;
      do begin
         tick();
         edges++;
      end while (busy_w0 && edges < 40);
      check(name, edges, 16);
   endtask

   initial begin
      reset = 1'b0; ce = 1'b0; oce = 1'b0; wre = 1'b0; ad = '0; din = '0;
      tick();
      tick();
      check("reset_busy", busy_w0, 1'b1);
      check("reset_dout", dout_w0, 8'h00);

      // Write attempt to address 2 held throughout the clear must be ignored.
      reset = 1'b1; ce = 1'b1; wre = 1'b1; ad = 4'd2; din = 8'hFF;
      count_clear("clear_len");
      ce = 1'b0; wre = 1'b0;

      for (int a = 0; a < 16; a++) begin
         op(1'b1, 1'b0, a[3:0], 8'h00, 1'b0);
         check(a == 2 ? "lockout_mem2" : "clear_word", dout_w0, 8'hA5);
      end

      op(1'b1, 1'b1, 4'h0, 8'h68, 1'b0);
      op(1'b1, 1'b1, 4'hB, 8'h0A, 1'b0);
      op(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
      check("raw_addr0", dout_w0, 8'h68);
      op(1'b1, 1'b0, 4'hB, 8'h00, 1'b0);
      check("raw_addrB", dout_w0, 8'h0A);

      op(1'b1, 1'b1, 4'h3, 8'h11, 1'b0);
      check("wt_first", dout_w1, 8'h11);
      check("rbw_first", dout_w2, 8'hA5);
      op(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
      op(1'b1, 1'b1, 4'h3, 8'h22, 1'b0);
      check("wm_normal", dout_w0, 8'h68);
      check("wm_through", dout_w1, 8'h22);
      check("wm_rbw", dout_w2, 8'h11);

      op(1'b1, 1'b1, 4'h5, 8'h77, 1'b0);
      op(1'b1, 1'b0, 4'h5, 8'h00, 1'b0);
      check("pipe_hold1", dout_p, 8'h00);
      op(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      check("pipe_hold2", dout_p, 8'h00);
      op(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      check("pipe_hold3", dout_p, 8'h00);
      op(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
      check("pipe_oce", dout_p, 8'h77);
      oce = 1'b0;

      reset = 1'b0;
      tick();
      check("pipe_reset_dout", dout_p, 8'h00);
      reset = 1'b1;
      repeat (9) begin
         tick();
         check("midclr_dout", dout_w0, 8'h00);
      end
      reset = 1'b0;
      tick();
      check("midclr_busy", busy_w0, 1'b1);
      reset = 1'b1;
      count_clear("reclear_len");

      op(1'b1, 1'b0, 4'h3, 8'h00, 1'b0);
      check("reclear_addr3", dout_w0, 8'hA5);
      op(1'b1, 1'b0, 4'h5, 8'h00, 1'b0);
      check("reclear_addr5", dout_w0, 8'hA5);
      op(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
